// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared mode encodings, pattern constants and helpers for the
// LED sequencer.
package led_seq_pkg;

  localparam int unsigned LED_W = 8;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_WALK   = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  localparam logic [LED_W-1:0] PAT_IDLE     = 8'hAA;
  localparam logic [LED_W-1:0] PAT_IDLE_ALT = 8'h55;
  localparam logic [LED_W-1:0] PAT_ZERO     = 8'h00;
  localparam logic [LED_W-1:0] PAT_ONE      = 8'h01;
  localparam logic [LED_W-1:0] PAT_TOP      = 8'h80;

  // Pattern loaded on entry to a mode.
  function automatic logic [LED_W-1:0] init_pattern(input mode_e m);
    logic [LED_W-1:0] p;
    case (m)
      MODE_IDLE:  p = PAT_IDLE;
      MODE_COUNT: p = PAT_ZERO;
      default:    p = PAT_ONE;
    endcase
    return p;
  endfunction

  // Mode order wraps BOUNCE back to IDLE.
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(2'(m + 2'd1));
  endfunction

endpackage

// File: rtl/led_seq_if.sv
// led_seq_if: button/pause inputs and LED/mode/tick outputs of the sequencer.
//   master: drives btn_next, pause; observes led, mode, tick
//   slave : the sequencer itself
interface led_seq_if;
  import led_seq_pkg::*;

  logic             btn_next;
  logic             pause;
  logic [LED_W-1:0] led;
  logic [1:0]       mode;
  logic             tick;

  modport master (output btn_next, output pause,
                  input  led, input mode, input tick);
  modport slave  (input  btn_next, input pause,
                  output led, output mode, output tick);
endinterface

// File: rtl/led_seq_prescaler.sv
// led_seq_prescaler: counts 0..PRESCALE-1 and raises a registered one-cycle
// tick while the count sits at PRESCALE-1. pause holds the count and keeps
// tick low; clr restarts from zero with tick low.
//   clk, rst (async, active-high), pause, clr -> tick
module led_seq_prescaler #(
  parameter int unsigned PRESCALE = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pause,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(PRESCALE - 2);

  logic [CNT_W-1:0] cnt;

  // tick is registered from the count about to become PRESCALE-1, so it is
  // high exactly while the count equals PRESCALE-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (pause) begin
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == CNT_PRE);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: LED pattern sequencer. A push-button cycles the display mode
// IDLE -> COUNT -> WALK -> BOUNCE; the prescaler tick steps the pattern.
//   clk, rst (async, active-high)
//   bus.btn_next (async button), bus.pause (freeze stepping)
//   bus.led[7:0], bus.mode[1:0], bus.tick (all registered)
// Build option: define LED_SEQ_DEBOUNCE_EN to require DEB_CYCLES consecutive
// high cycles of the synchronised button before a press is accepted.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned PRESCALE   = 10_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  led_seq_if.slave    bus
);

  mode_e            mode_q, mode_nxt;
  logic [LED_W-1:0] led_q, led_nxt;
  logic             dir_left_q, dir_left_nxt;
  logic             sync1, sync2;
  logic             press_c;
  logic             tick_q;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.btn_next;
      sync2 <= sync1;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

  logic [DEB_W-1:0] deb_cnt;

  // Counts consecutive high cycles and saturates, so one long press is
  // accepted once and the button must drop before the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
    end else if (!sync2) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DEB_W'(DEB_CYCLES)) begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  assign press_c = sync2 && (deb_cnt == DEB_W'(DEB_CYCLES - 1));
`else
  logic sync2_d;

  // Previous synchronised value for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync2_d <= 1'b0;
    else     sync2_d <= sync2;
  end

  assign press_c = sync2 && !sync2_d;

  // DEB_CYCLES has no effect in this build.
  if (DEB_CYCLES != 0) begin : g_deb_unused
  end
`endif

  // A mode change also clears the prescaler so the new pattern gets a full
  // step period before it first moves.
  led_seq_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .pause (bus.pause),
    .clr   (press_c),
    .tick  (tick_q)
  );

  // Mode / pattern state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_IDLE;
      led_q      <= PAT_IDLE;
      dir_left_q <= 1'b1;
    end else begin
      mode_q     <= mode_nxt;
      led_q      <= led_nxt;
      dir_left_q <= dir_left_nxt;
    end
  end

  // Next mode and pattern; a press wins over a coincident tick.
  always_comb begin
    mode_nxt     = mode_q;
    led_nxt      = led_q;
    dir_left_nxt = dir_left_q;
    if (press_c) begin
      mode_nxt     = next_mode(mode_q);
      led_nxt      = init_pattern(mode_nxt);
      dir_left_nxt = 1'b1;
    end else if (tick_q) begin
      case (mode_q)
        MODE_IDLE:  led_nxt = (led_q == PAT_IDLE) ? PAT_IDLE_ALT : PAT_IDLE;
        MODE_COUNT: led_nxt = led_q + LED_W'(1);
        MODE_WALK:  led_nxt = {led_q[LED_W-2:0], led_q[LED_W-1]};
        MODE_BOUNCE: begin
          // Reverse at the end bits, moving straight back one place.
          if (dir_left_q) begin
            if (led_q == PAT_TOP) begin
              dir_left_nxt = 1'b0;
              led_nxt      = led_q >> 1;
            end else begin
              led_nxt = led_q << 1;
            end
          end else begin
            if (led_q == PAT_ONE) begin
              dir_left_nxt = 1'b1;
              led_nxt      = led_q << 1;
            end else begin
              led_nxt = led_q >> 1;
            end
          end
        end
        default: led_nxt = led_q;
      endcase
    end
  end

  assign bus.led  = led_q;
  assign bus.mode = mode_q;
  assign bus.tick = tick_q;

endmodule
